// File: rtl/tipi_rpi_read_path.sv
// tipi_rpi_read_path: RPi->TI mailbox half; serial shift into RD/RC and TI read-cycle bus drive.
module tipi_rpi_read_path #(
    parameter logic [15:0] RD_ADDR = 16'h5ffb,
    parameter logic [15:0] RC_ADDR = 16'h5ff9,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r_clk,
    input  logic        r_dout,
    input  logic        r_le,
    input  logic        r_rt,
    input  logic        tipi_enable,
    input  logic [0:15] ti_a,
    input  logic        ti_memen,
    input  logic        ti_dbin,
    output logic [0:7]  ti_dout,
    output logic        tipi_data_out,
    output logic        tipi_control_out,
    output logic        rd_read,
    output logic        frame_err
);
    logic [SYNC_STAGES-1:0] clk_p, dout_p, le_p, rt_p, memen_p, dbin_p;
    logic [15:0] a_p [SYNC_STAGES];
    logic clk_s, dout_s, le_s, rt_s, memen_s, dbin_s;
    logic [15:0] a_s;
    logic clk_d, le_d, clk_rise, le_rise;
    logic [7:0] shift, shift_next, rd_q, rc_q, pending;
    logic [3:0] bitcnt, bitcnt_next;
    logic pend_tgt, pend_v, rd_cyc, rc_cyc, defer, apply;

    assign clk_s   = clk_p[SYNC_STAGES-1];
    assign dout_s  = dout_p[SYNC_STAGES-1];
    assign le_s    = le_p[SYNC_STAGES-1];
    assign rt_s    = rt_p[SYNC_STAGES-1];
    assign memen_s = memen_p[SYNC_STAGES-1];
    assign dbin_s  = dbin_p[SYNC_STAGES-1];
    assign a_s     = a_p[SYNC_STAGES-1];

    // ti_a rides the same pipeline depth as the strobes so address and strobes stay aligned
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_p   <= '0;
            dout_p  <= '0;
            le_p    <= '0;
            rt_p    <= '0;
            memen_p <= '1;
            dbin_p  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) a_p[i] <= '0;
        end else begin
            clk_p   <= {clk_p[SYNC_STAGES-2:0], r_clk};
            dout_p  <= {dout_p[SYNC_STAGES-2:0], r_dout};
            le_p    <= {le_p[SYNC_STAGES-2:0], r_le};
            rt_p    <= {rt_p[SYNC_STAGES-2:0], r_rt};
            memen_p <= {memen_p[SYNC_STAGES-2:0], ti_memen};
            dbin_p  <= {dbin_p[SYNC_STAGES-2:0], ti_dbin};
            a_p[0]  <= ti_a;
            for (int i = 1; i < SYNC_STAGES; i++) a_p[i] <= a_p[i-1];
        end
    end

    always_comb begin
        clk_rise    = clk_s & ~clk_d;
        le_rise     = le_s & ~le_d;
        shift_next  = clk_rise ? {shift[6:0], dout_s} : shift;
        bitcnt_next = clk_rise ? ((bitcnt == 4'd15) ? bitcnt : bitcnt + 4'd1) : bitcnt;
        rd_cyc      = tipi_enable & ~memen_s & dbin_s & (a_s == RD_ADDR);
        rc_cyc      = tipi_enable & ~memen_s & dbin_s & (a_s == RC_ADDR);
        defer       = rt_s ? rc_cyc : rd_cyc;
        apply       = pend_v & ~(pend_tgt ? rc_cyc : rd_cyc);
    end

    // A latch into the register under read is parked in pending until that read ends
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_d            <= 1'b0;
            le_d             <= 1'b0;
            shift            <= '0;
            bitcnt           <= '0;
            rd_q             <= '0;
            rc_q             <= '0;
            pending          <= '0;
            pend_tgt         <= 1'b0;
            pend_v           <= 1'b0;
            ti_dout          <= '0;
            tipi_data_out    <= 1'b1;
            tipi_control_out <= 1'b1;
            rd_read          <= 1'b0;
            frame_err        <= 1'b0;
        end else begin
            clk_d  <= clk_s;
            le_d   <= le_s;
            shift  <= shift_next;
            bitcnt <= le_rise ? 4'd0 : bitcnt_next;
            if (le_rise && bitcnt_next != 4'd8) frame_err <= 1'b1;
            if (apply) pend_v <= 1'b0;
            if (apply && !pend_tgt) rd_q <= pending;
            if (apply && pend_tgt) rc_q <= pending;
            if (le_rise && defer) begin
                pending  <= shift_next;
                pend_tgt <= rt_s;
                pend_v   <= 1'b1;
            end else if (le_rise && rt_s) rc_q <= shift_next;
            else if (le_rise) rd_q <= shift_next;
            tipi_data_out    <= ~rd_cyc;
            tipi_control_out <= ~rc_cyc;
            ti_dout          <= rc_cyc ? rc_q : rd_q;
            rd_read          <= ~tipi_data_out & ~rd_cyc;
        end
    end
endmodule

// File: tb/tb_tipi_rpi_read_path.sv
// tb_tipi_rpi_read_path: directed + random bench against a bit-queue mailbox model.
module tb_tipi_rpi_read_path;
    logic clk = 1'b0;
    logic rst_n, r_clk, r_dout, r_le, r_rt, tipi_enable, ti_memen, ti_dbin;
    logic [0:15] ti_a;
    logic [0:7] ti_dout;
    logic tipi_data_out, tipi_control_out, rd_read, frame_err;
    int total = 0, bad = 0;
    bit q[$];
    int m_cnt = 0;
    logic [7:0] m_rd = 8'h00, m_rc = 8'h00;
    logic m_ferr = 1'b0;
    localparam logic [15:0] RD = 16'h5ffb, RC = 16'h5ff9;

    always #10 clk = ~clk;

    tipi_rpi_read_path dut (
        .clk(clk), .rst_n(rst_n), .r_clk(r_clk), .r_dout(r_dout), .r_le(r_le), .r_rt(r_rt),
        .tipi_enable(tipi_enable), .ti_a(ti_a), .ti_memen(ti_memen), .ti_dbin(ti_dbin),
        .ti_dout(ti_dout), .tipi_data_out(tipi_data_out), .tipi_control_out(tipi_control_out),
        .rd_read(rd_read), .frame_err(frame_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] last8();
        logic [7:0] v = '0;
        for (int k = 0; k < 8 && k < q.size(); k++) v[k] = q[q.size()-1-k];
        return v;
    endfunction

    task automatic send(input logic [7:0] b, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            r_dout = b[i];
            wclk(4);
            r_clk = 1'b1;
            wclk(4);
            r_clk = 1'b0;
            q.push_back(b[i]);
            m_cnt++;
        end
    endtask

    task automatic model_latch(input logic rt);
        m_ferr = m_ferr | (m_cnt != 8);
        m_cnt = 0;
        if (rt) m_rc = last8(); else m_rd = last8();
    endtask

    task automatic latch(input logic rt);
        r_rt = rt;
        wclk(4);
        r_le = 1'b1;
        wclk(4);
        r_le = 1'b0;
        wclk(4);
        model_latch(rt);
    endtask

    task automatic start_read(input logic [15:0] addr, input logic dbin, input logic en);
        ti_a = addr;
        tipi_enable = en;
        ti_dbin = dbin;
        ti_memen = 1'b0;
        wclk(6);
    endtask

    task automatic end_read(input int exp_pulses);
        int cnt = 0;
        ti_memen = 1'b1;
        ti_dbin = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rd_read) cnt++;
        end
        chk("rd_read_pulses", 16'(cnt), 16'(exp_pulses));
        chk("oe_idle", {tipi_data_out, tipi_control_out}, 2'b11);
    endtask

    task automatic read_check(input logic [15:0] addr, input logic [7:0] exp, input string tag);
        start_read(addr, 1'b1, 1'b1);
        chk({tag, "_oe"}, {tipi_data_out, tipi_control_out}, (addr == RD) ? 2'b01 : 2'b10);
        chk({tag, "_dout"}, ti_dout, exp);
        end_read((addr == RD) ? 1 : 0);
    endtask

    initial begin
        logic [7:0] b, old;
        logic rt, sel;
        int cnt;
        rst_n = 1'b0; r_clk = 1'b0; r_dout = 1'b0; r_le = 1'b0; r_rt = 1'b0;
        tipi_enable = 1'b1; ti_memen = 1'b1; ti_dbin = 1'b0; ti_a = 16'h0000;
        wclk(4);
        chk("reset_dout", ti_dout, 8'h00);
        chk("reset_oe", {tipi_data_out, tipi_control_out}, 2'b11);
        chk("reset_flags", {rd_read, frame_err}, 2'b00);
        rst_n = 1'b1;
        wclk(2);

        send(8'hA5, 8); latch(1'b0);
        read_check(RD, m_rd, "rd_a5");
        chk("ferr_a5", frame_err, 1'b0);

        send(8'h3C, 8); latch(1'b1);
        read_check(RC, m_rc, "rc_3c");

        send(8'h11, 8); latch(1'b0);
        start_read(RD, 1'b1, 1'b1);
        chk("stab_before", ti_dout, 8'h11);
        send(8'h22, 8); latch(1'b0);
        chk("stab_after_latch", ti_dout, 8'h11);
        chk("stab_oe", tipi_data_out, 1'b0);
        end_read(1);
        read_check(RD, 8'h22, "rd_22");
        read_check(RC, 8'h3C, "rc_kept");

        for (int it = 0; it < 6; it++) begin
            b = 8'($urandom);
            rt = 1'($urandom_range(0, 1));
            sel = 1'($urandom_range(0, 1));
            old = sel ? m_rc : m_rd;
            start_read(sel ? RC : RD, 1'b1, 1'b1);
            send(b, 8); latch(rt);
            chk("rnd_hold", ti_dout, old);
            end_read(sel ? 0 : 1);
            read_check(RD, m_rd, "rnd_rd");
            read_check(RC, m_rc, "rnd_rc");
        end

        b = 8'h96;
        send(b >> 1, 7);
        r_dout = b[0]; r_rt = 1'b1;
        wclk(4);
        r_clk = 1'b1; r_le = 1'b1;
        wclk(4);
        r_clk = 1'b0; r_le = 1'b0;
        wclk(4);
        q.push_back(b[0]); m_cnt++;
        model_latch(1'b1);
        chk("simul_ferr", frame_err, m_ferr);
        read_check(RC, m_rc, "simul_rc");
        send(8'h5A, 8); latch(1'b0);
        chk("simul_cnt_reset", frame_err, 1'b0);

        send(8'h7F, 7); latch(1'b0);
        chk("short_ferr", frame_err, m_ferr);
        read_check(RD, m_rd, "short_rd");
        send(8'hC3, 8); latch(1'b0);
        chk("ferr_sticky", frame_err, 1'b1);

        rst_n = 1'b0;
        wclk(2);
        chk("rst2_ferr", frame_err, 1'b0);
        chk("rst2_oe", {tipi_data_out, tipi_control_out}, 2'b11);
        chk("rst2_dout", ti_dout, 8'h00);
        rst_n = 1'b1;
        q.delete(); m_cnt = 0; m_rd = 8'h00; m_rc = 8'h00; m_ferr = 1'b0;
        wclk(2);
        read_check(RD, 8'h00, "rst2_rd");

        send(8'hE7, 8); latch(1'b0);
        start_read(RD, 1'b1, 1'b0);
        chk("dis_oe", {tipi_data_out, tipi_control_out}, 2'b11);
        end_read(0);
        start_read(16'h5ffd, 1'b1, 1'b1);
        chk("other_addr_oe", {tipi_data_out, tipi_control_out}, 2'b11);
        end_read(0);
        start_read(RD, 1'b0, 1'b1);
        chk("write_oe", {tipi_data_out, tipi_control_out}, 2'b11);
        end_read(0);

        start_read(RD, 1'b1, 1'b1);
        chk("drop_oe_on", tipi_data_out, 1'b0);
        chk("drop_dout", ti_dout, m_rd);
        tipi_enable = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rd_read) cnt++;
        end
        chk("drop_rd_read", 16'(cnt), 16'd1);
        chk("drop_oe_off", tipi_data_out, 1'b1);
        end_read(0);
        tipi_enable = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
